router_input_unit: RTL and testbench
====================================

# router_input_unit

Per-input-port front end of the NoC router: buffers incoming flits, computes the XY route for each packet, and presents `request`/`req_port` to the matrix switch arbiter one packet at a time (wormhole). One instance per router input port; its `request`/`req_port` bits concatenate into the arbiter's `requests`/`req_ports` buses, and the arbiter's per-port `grant` bit comes back to pop the buffer and return a credit upstream.

## Interface
Parameters:
- `DATA_WIDTH`, 16: payload bits.
- `APP_ID_WIDTH`, 4: application ID bits.
- `ADDR_WIDTH`, 4: width of each of X_ADDR and Y_ADDR.
- `EXTRA_WIDTH`, 4: EXTRA field bits, passed through untouched.
- `FLIT_WIDTH`, EXTRA_WIDTH+2+2*ADDR_WIDTH+APP_ID_WIDTH+DATA_WIDTH (=34): derived, not overridden.
- `DEPTH`, 4: flit buffer entries, power of 2, ≥2.
- `MY_X`, 0 / `MY_Y`, 0: this router's coordinates.
- `OUT_PORT_BITS`, 3: width of the output port index.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ON` in 1: router enable; low freezes requests and pops.
- `in_valid` in 1: upstream flit strobe.
- `in_flit` in FLIT_WIDTH: layout MSB→LSB {EXTRA, TYPE[1:0], Y_ADDR, X_ADDR, APP_ID, DATA}.
- `credit_out` out 1: one-cycle pulse per buffer entry freed.
- `request` out 1: to arbiter `requests[n]`.
- `req_port` out OUT_PORT_BITS: to arbiter `req_ports[n]`.
- `grant` in 1: from arbiter `grants[n]`, same-cycle combinational response to `request`.
- `out_flit` out FLIT_WIDTH: buffer head, to crossbar; valid when `request & grant`.
- `err_overflow` out 1: sticky, flit arrived when full.
- `err_protocol` out 1: sticky, malformed packet sequence.

## Operation
- TYPE encoding: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE. Route fields read only from HEAD/SINGLE.
- Port encoding: 0 LOCAL, 1 NORTH (+Y), 2 EAST (+X), 3 SOUTH (−Y), 4 WEST (−X).
- XY route (unsigned compare): X_ADDR>MY_X→EAST; X_ADDR<MY_X→WEST; else Y_ADDR>MY_Y→NORTH; Y_ADDR<MY_Y→SOUTH; else LOCAL.
- Buffer: DEPTH-entry circular FIFO, wrapping read/write pointers, occupancy counter 0..DEPTH. Push when `in_valid` and (not full or pop this cycle). `in_valid` while full with no pop: flit discarded, `err_overflow` set.
- FSM states IDLE, ACTIVE:
  - IDLE, buffer empty: stay; `request`=0.
  - IDLE, head TYPE HEAD/SINGLE, `ON`=1: latch route into `req_port`, go ACTIVE (no pop).
  - IDLE, head TYPE BODY/TAIL, `ON`=1: pop and discard (orphan), pulse `credit_out`, set `err_protocol`, stay IDLE.
  - ACTIVE: `request` = `ON` & buffer non-empty. On `request & grant`: pop, pulse `credit_out`; if popped TYPE is TAIL/SINGLE go IDLE, else stay.
  - ACTIVE, head TYPE HEAD (missing tail): `request`=0, no pop, set `err_protocol`, go IDLE; the HEAD is routed fresh next cycle.
- `req_port` holds its latched value until the next route latch; `request` is combinational from state, `ON`, occupancy and head TYPE.
- `grant` while `request`=0 ignored.
- `ON`=0: pushes still accepted; no route latch, no pop, `request`=0; state and pointers held.

## Timing
- Reset values: FIFO empty, pointers 0, state IDLE, `request`=0, `req_port`=0, `credit_out`=0, `err_overflow`=0, `err_protocol`=0. Reset mid-packet discards all buffered flits without credit pulses; upstream resets its credit counter on the same `reset`.
- Latency: flit pushed at edge t; route latched at edge t+1; `request` high in cycle after edge t+1; granted flit popped at that cycle's closing edge.
- Throughput: one flit/cycle while granted back-to-back; HEAD after a TAIL costs one IDLE cycle (no request).
- `credit_out` asserted in the cycle following the pop edge, one pulse per freed entry; simultaneous push and pop at full allowed, occupancy unchanged.

## Test plan
- MY_X=1,MY_Y=1; SINGLE flit X=3,Y=0, `grant` tied to `request` → `req_port`=2, `request` one cycle, `credit_out` one pulse, `out_flit` equals input.
- HEAD/BODY/TAIL to X=1,Y=1, `grant` held 0 for 3 cycles then 1 → `req_port`=0, `request` held throughout, three consecutive pops, FSM IDLE after TAIL.
- DEPTH=4, `grant`=0, 5 back-to-back flits → occupancy 4, fifth discarded, `err_overflow`=1, first four delivered in order.
- BODY flit into empty IDLE unit → discarded, `credit_out` pulse, `err_protocol`=1, `request` never asserted.
- HEAD X=0,Y=1 then HEAD X=1,Y=2 without TAIL → first `req_port`=4, `err_protocol`=1, second HEAD re-routed `req_port`=1.
- `ON`=0 during buffered packet → `request`=0, no pops; `ON`=1 → resumes; `reset` mid-packet → all outputs to reset values next cycle.

Source files
------------

// File: rtl/router_input_unit.sv
// router_input_unit
//   Per-input-port NoC router front end. Buffers incoming flits in a small
//   circular FIFO, computes the XY route of each packet from its HEAD/SINGLE
//   flit and requests one output port at a time (wormhole) from the switch
//   arbiter. Each granted or discarded flit frees a buffer entry and returns
//   a one-cycle credit pulse upstream.
//
// Ports
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   ON            : router enable; low freezes route latch, pops and requests
//   in_valid      : upstream flit strobe
//   in_flit       : {EXTRA, TYPE[1:0], Y_ADDR, X_ADDR, APP_ID, DATA}
//   credit_out    : one pulse per freed buffer entry (cycle after the pop)
//   request       : to arbiter requests[n]
//   req_port      : latched output port of the current packet
//   grant         : from arbiter grants[n], same-cycle response to request
//   out_flit      : buffer head flit, valid when request & grant
//   err_overflow  : sticky, flit arrived while full
//   err_protocol  : sticky, malformed packet sequence
module router_input_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int APP_ID_WIDTH  = 4,
  parameter int ADDR_WIDTH    = 4,
  parameter int EXTRA_WIDTH   = 4,
  localparam int FLIT_WIDTH   = EXTRA_WIDTH + 2 + 2*ADDR_WIDTH + APP_ID_WIDTH + DATA_WIDTH,
  parameter int DEPTH         = 4,
  parameter int MY_X          = 0,
  parameter int MY_Y          = 0,
  parameter int OUT_PORT_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ON,
  input  logic                     in_valid,
  input  logic [FLIT_WIDTH-1:0]    in_flit,
  output logic                     credit_out,
  output logic                     request,
  output logic [OUT_PORT_BITS-1:0] req_port,
  input  logic                     grant,
  output logic [FLIT_WIDTH-1:0]    out_flit,
  output logic                     err_overflow,
  output logic                     err_protocol
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int X_LSB    = APP_ID_WIDTH + DATA_WIDTH;
  localparam int Y_LSB    = X_LSB + ADDR_WIDTH;
  localparam int TYPE_LSB = Y_LSB + ADDR_WIDTH;

  localparam logic [1:0] TY_HEAD   = 2'b00;
  localparam logic [1:0] TY_BODY   = 2'b01;
  localparam logic [1:0] TY_TAIL   = 2'b10;
  localparam logic [1:0] TY_SINGLE = 2'b11;

  localparam logic [OUT_PORT_BITS-1:0] P_LOCAL = OUT_PORT_BITS'(0);
  localparam logic [OUT_PORT_BITS-1:0] P_NORTH = OUT_PORT_BITS'(1);
  localparam logic [OUT_PORT_BITS-1:0] P_EAST  = OUT_PORT_BITS'(2);
  localparam logic [OUT_PORT_BITS-1:0] P_SOUTH = OUT_PORT_BITS'(3);
  localparam logic [OUT_PORT_BITS-1:0] P_WEST  = OUT_PORT_BITS'(4);

  localparam logic [ADDR_WIDTH-1:0] MY_X_A = ADDR_WIDTH'(MY_X);
  localparam logic [ADDR_WIDTH-1:0] MY_Y_A = ADDR_WIDTH'(MY_Y);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Buffer
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  state_t                   r_state;
  state_t                   w_next;
  logic [OUT_PORT_BITS-1:0] r_req_port;
  logic                     r_hdr_sent;
  logic                     r_credit;
  logic                     r_err_ovf;
  logic                     r_err_prot;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_ovf;
  logic                     w_request;
  logic                     w_latch;
  logic                     w_proto_err;
  logic                     w_head_start;
  logic [FLIT_WIDTH-1:0]    w_head;
  logic [1:0]               w_head_type;
  logic [ADDR_WIDTH-1:0]    w_head_x;
  logic [ADDR_WIDTH-1:0]    w_head_y;
  logic [OUT_PORT_BITS-1:0] w_route;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_type  = w_head[TYPE_LSB +: 2];
  assign w_head_x     = w_head[X_LSB +: ADDR_WIDTH];
  assign w_head_y     = w_head[Y_LSB +: ADDR_WIDTH];
  assign w_head_start = (w_head_type == TY_HEAD) || (w_head_type == TY_SINGLE);

  // A flit may enter a full buffer only when an entry leaves in the same cycle.
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_ovf  = in_valid && w_full && !w_pop;

  // XY dimension-order route from the head flit
  always_comb begin
    w_route = P_LOCAL;
    if (w_head_x > MY_X_A)      w_route = P_EAST;
    else if (w_head_x < MY_X_A) w_route = P_WEST;
    else if (w_head_y > MY_Y_A) w_route = P_NORTH;
    else if (w_head_y < MY_Y_A) w_route = P_SOUTH;
  end

  // Packet FSM: next state and per-cycle controls
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_request   = 1'b0;
    w_latch     = 1'b0;
    w_proto_err = 1'b0;
    if (ON && !w_empty) begin
      case (r_state)
        S_IDLE: begin
          if (w_head_start) begin
            w_latch = 1'b1;
            w_next  = S_ACTIVE;
          end else begin
            // orphan BODY/TAIL: drop it and return its credit
            w_pop       = 1'b1;
            w_proto_err = 1'b1;
          end
        end
        S_ACTIVE: begin
          // A packet start behind an already-forwarded header means the
          // previous packet lost its tail; abandon it and re-route the new one.
          if (w_head_start && r_hdr_sent) begin
            w_proto_err = 1'b1;
            w_next      = S_IDLE;
          end else begin
            w_request = 1'b1;
            if (grant) begin
              w_pop = 1'b1;
              if ((w_head_type == TY_TAIL) || (w_head_type == TY_SINGLE))
                w_next = S_IDLE;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_req_port <= '0;
      r_hdr_sent <= 1'b0;
      r_credit   <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_prot <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_credit <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_latch) begin
        r_req_port <= w_route;
        r_hdr_sent <= 1'b0;
      end else if (w_pop) begin
        r_hdr_sent <= 1'b1;
      end
      if (w_ovf)       r_err_ovf  <= 1'b1;
      if (w_proto_err) r_err_prot <= 1'b1;
    end
  end

  assign request      = w_request;
  assign req_port     = r_req_port;
  assign credit_out   = r_credit;
  assign out_flit     = w_head;
  assign err_overflow = r_err_ovf;
  assign err_protocol = r_err_prot;

  // TY_BODY names the remaining encoding; BODY flits take the default paths.
  logic w_unused_body;
  assign w_unused_body = (w_head_type == TY_BODY);

endmodule

// File: tb/tb_router_input_unit.sv
// Testbench for router_input_unit (MY_X=1, MY_Y=1, DEPTH=4): cycle-by-cycle
// vector table plus a hand-written full-buffer push/pop sequence.
module tb_router_input_unit;

  localparam int FW = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic          ON;
  logic          in_valid;
  logic [FW-1:0] in_flit;
  logic          credit_out;
  logic          request;
  logic [2:0]    req_port;
  logic          grant;
  logic [FW-1:0] out_flit;
  logic          err_overflow;
  logic          err_protocol;

  always #5 clk = ~clk;

  router_input_unit #(
    .DATA_WIDTH(16), .APP_ID_WIDTH(4), .ADDR_WIDTH(4), .EXTRA_WIDTH(4),
    .DEPTH(4), .MY_X(1), .MY_Y(1), .OUT_PORT_BITS(3)
  ) dut (
    .clk(clk), .reset(reset), .ON(ON), .in_valid(in_valid), .in_flit(in_flit),
    .credit_out(credit_out), .request(request), .req_port(req_port),
    .grant(grant), .out_flit(out_flit),
    .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, SG = 2'b11;

  function automatic logic [FW-1:0] mk(logic [1:0] t, logic [3:0] x, logic [3:0] y,
                                       logic [15:0] d);
    return {4'hA, t, y, x, 4'h5, d};
  endfunction

  typedef struct {
    logic          rst, on, vld;
    logic [FW-1:0] flit;
    logic          gnt, chk;
    logic          req;
    logic [2:0]    port;
    logic          cred, ovf, prot, cf;
    logic [FW-1:0] ef;
  } vec_t;

  function automatic vec_t V(logic r, logic o, logic v, logic [FW-1:0] f, logic g,
                             logic c, logic rq, logic [2:0] p, logic cr,
                             logic ov, logic pr, logic cf, logic [FW-1:0] ef);
    vec_t t;
    t.rst = r; t.on = o; t.vld = v; t.flit = f; t.gnt = g; t.chk = c;
    t.req = rq; t.port = p; t.cred = cr; t.ovf = ov; t.prot = pr;
    t.cf = cf; t.ef = ef;
    return t;
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, int idx, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  vec_t          vq[$];
  vec_t          v;
  logic [FW-1:0] S1, H2, B2, T2, H3, B3a, B3b, T3, X3, B4, H5a, H5b, B5, T5;
  logic [FW-1:0] H6, B6a, B6b, B6c, T6;
  logic [FW-1:0] hexp [5];

  initial begin
    S1  = mk(SG, 4'd3, 4'd0, 16'hA001);
    H2  = mk(HD, 4'd1, 4'd1, 16'hB000);
    B2  = mk(BD, 4'd7, 4'd7, 16'hB001);
    T2  = mk(TL, 4'd7, 4'd7, 16'hB002);
    H3  = mk(HD, 4'd1, 4'd0, 16'hC000);
    B3a = mk(BD, 4'd0, 4'd0, 16'hC001);
    B3b = mk(BD, 4'd0, 4'd0, 16'hC002);
    T3  = mk(TL, 4'd0, 4'd0, 16'hC003);
    X3  = mk(BD, 4'd0, 4'd0, 16'hC0FF);
    B4  = mk(BD, 4'd2, 4'd2, 16'hD001);
    H5a = mk(HD, 4'd0, 4'd1, 16'hE000);
    H5b = mk(HD, 4'd1, 4'd2, 16'hE100);
    B5  = mk(BD, 4'd0, 4'd0, 16'hE101);
    T5  = mk(TL, 4'd0, 4'd0, 16'hE102);

    //               r on v flit g  c  rq port cr ov pr cf ef
    // reset and idle reset state
    vq.push_back(V(1,1,0,'0 ,0, 0, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,0, 1, 0,0,0,0,0, 0,'0));
    // SINGLE to (3,0) -> EAST, grant follows request
    vq.push_back(V(0,1,1,S1 ,0, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,0, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,2,0,0,0, 1,S1));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,2,1,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,0, 1, 0,2,0,0,0, 0,'0));
    // HEAD/BODY/TAIL to (1,1) -> LOCAL, grant low 3 cycles
    vq.push_back(V(0,1,1,H2 ,0, 1, 0,2,0,0,0, 0,'0));
    vq.push_back(V(0,1,1,B2 ,0, 1, 0,2,0,0,0, 0,'0));
    vq.push_back(V(0,1,1,T2 ,0, 1, 1,0,0,0,0, 1,H2));
    vq.push_back(V(0,1,0,'0 ,0, 1, 1,0,0,0,0, 1,H2));
    vq.push_back(V(0,1,0,'0 ,0, 1, 1,0,0,0,0, 1,H2));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,0,0,0,0, 1,H2));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,0,1,0,0, 1,B2));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,0,1,0,0, 1,T2));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,0,1,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,0, 1, 0,0,0,0,0, 0,'0));
    // five back-to-back flits into DEPTH=4, fifth discarded; (1,0) -> SOUTH
    vq.push_back(V(0,1,1,H3 ,0, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,1,B3a,0, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,1,B3b,0, 1, 1,3,0,0,0, 1,H3));
    vq.push_back(V(0,1,1,T3 ,0, 1, 1,3,0,0,0, 1,H3));
    vq.push_back(V(0,1,1,X3 ,0, 1, 1,3,0,0,0, 1,H3));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,3,0,1,0, 1,H3));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,3,1,1,0, 1,B3a));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,3,1,1,0, 1,B3b));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,3,1,1,0, 1,T3));
    vq.push_back(V(0,1,0,'0 ,0, 1, 0,3,1,1,0, 0,'0));
    // orphan BODY into idle unit
    vq.push_back(V(0,1,1,B4 ,1, 1, 0,3,0,1,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,3,0,1,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,3,1,1,1, 0,'0));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,3,0,1,1, 0,'0));
    // reset, then HEAD (0,1)->WEST followed by HEAD (1,2)->NORTH without TAIL
    vq.push_back(V(1,1,0,'0 ,0, 0, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,1,H5a,0, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,1,H5b,0, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,4,0,0,0, 1,H5a));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,4,1,0,0, 1,H5b));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,4,0,0,1, 1,H5b));
    vq.push_back(V(0,1,1,B5 ,0, 1, 1,1,0,0,1, 1,H5b));
    // ON low mid-packet: no request, no pop; pushes still land
    vq.push_back(V(0,0,1,T5 ,1, 1, 0,1,0,0,1, 1,H5b));
    vq.push_back(V(0,0,0,'0 ,1, 1, 0,1,0,0,1, 1,H5b));
    vq.push_back(V(0,1,0,'0 ,1, 1, 1,1,0,0,1, 1,H5b));
    vq.push_back(V(0,1,0,'0 ,0, 1, 1,1,1,0,1, 1,B5));
    // reset mid-packet: everything back to reset values, buffer emptied
    vq.push_back(V(1,1,0,'0 ,0, 1, 1,1,0,0,1, 1,B5));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,0,0,0,0, 0,'0));
    vq.push_back(V(0,1,0,'0 ,1, 1, 0,0,0,0,0, 0,'0));

    for (int i = 0; i < vq.size(); i++) begin
      v        = vq[i];
      reset    = v.rst;
      ON       = v.on;
      in_valid = v.vld;
      in_flit  = v.flit;
      grant    = v.gnt;
      #2;
      if (v.chk) begin
        chk("request",      i, FW'(request),      FW'(v.req));
        chk("req_port",     i, FW'(req_port),     FW'(v.port));
        chk("credit_out",   i, FW'(credit_out),   FW'(v.cred));
        chk("err_overflow", i, FW'(err_overflow), FW'(v.ovf));
        chk("err_protocol", i, FW'(err_protocol), FW'(v.prot));
        if (v.cf) chk("out_flit", i, out_flit, v.ef);
      end
      @(posedge clk); #1;
    end

    // Full buffer: push and pop in the same cycle keeps occupancy, no overflow.
    H6  = mk(HD, 4'd1, 4'd3, 16'hF000);
    B6a = mk(BD, 4'd0, 4'd0, 16'hF001);
    B6b = mk(BD, 4'd0, 4'd0, 16'hF002);
    B6c = mk(BD, 4'd0, 4'd0, 16'hF003);
    T6  = mk(TL, 4'd0, 4'd0, 16'hF004);
    hexp[0] = H6; hexp[1] = B6a; hexp[2] = B6b; hexp[3] = B6c; hexp[4] = T6;
    reset = 1'b0; ON = 1'b1; grant = 1'b0;
    in_valid = 1'b1; in_flit = H6;  @(posedge clk); #1;
    in_flit = B6a;                  @(posedge clk); #1;
    in_flit = B6b;                  @(posedge clk); #1;
    in_flit = B6c;                  @(posedge clk); #1;
    in_flit = T6; grant = 1'b1;     #1;
    chk("full_req",  100, FW'(request),  FW'(1'b1));
    chk("full_port", 100, FW'(req_port), FW'(3'd1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk("drain_req",  100 + k, FW'(request),      FW'(1'b1));
      chk("drain_flit", 100 + k, out_flit,          hexp[k]);
      chk("drain_ovf",  100 + k, FW'(err_overflow), FW'(1'b0));
      @(posedge clk); #1;
    end
    #1;
    chk("drain_end_req",  105, FW'(request),    FW'(1'b0));
    chk("drain_end_cred", 105, FW'(credit_out), FW'(1'b1));
    chk("drain_end_ovf",  105, FW'(err_overflow), FW'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
